// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, default parameters and address mapping for sram_controller.
package sram_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_e;
    localparam int          WAIT_CYCLES_DEF = 5;
    localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
    localparam int          SRAM_AW_DEF     = 18;

    // Word index shifted up one bit; hi selects the upper 16-bit half.
    function automatic logic [31:0] half_addr(input logic [31:0] a, input logic [31:0] base, input logic hi);
        return (((a - base) >> 2) << 1) | {31'd0, hi};
    endfunction
endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request bus plus SRAM pin bundle.
interface sram_controller_if import sram_pkg::*; #(parameter int SRAM_AW = SRAM_AW_DEF);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: half-access wait counter; tc marks the last cycle and wraps the count to 0.
module sram_wait_counter import sram_pkg::*; #(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [3:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == 4'(WAIT_CYCLES - 1));

    always_comb cnt_d = (clr || tc) ? 4'd0 : en ? cnt_q + 4'd1 : cnt_q;

    always_ff @(posedge clk)
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage loads/stores into two timed 16-bit SRAM accesses, freezing the pipeline via ready.
// Define SRAM_WRITE_POST_EN to post stores (no stall, FSM skips DONE).
module sram_controller import sram_pkg::*; #(
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = SRAM_AW_DEF
) (
    input logic               clk,
    input logic               rst,
    sram_controller_if.slave  bus
);
`ifdef SRAM_WRITE_POST_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req, busy, tc, hi;

    assign req  = bus.rd_en | bus.wr_en;
    assign busy = (state_q == LOW) || (state_q == HIGH);
    assign hi   = state_q == HIGH;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!busy),
        .en  (busy),
        .tc  (tc)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: if (req) begin
                state_d = LOW;
                wr_d    = bus.wr_en & ~bus.rd_en;
                addr_d  = bus.address;
                wdata_d = bus.write_data;
            end
            LOW:  if (tc) state_d = HIGH;
            HIGH: if (tc) state_d = (POST && wr_q) ? IDLE : DONE;
            DONE: state_d = IDLE;
        endcase
        if (tc && !wr_q)
            rdata_d = hi ? {bus.sram_dq_in, rdata_q[15:0]} : {rdata_q[31:16], bus.sram_dq_in};
    end

    // addr_q resets to BASE_ADDR so the idle SRAM address maps to half-word 0.
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end

    assign bus.read_data   = rdata_q;
    assign bus.ready       = (state_q == IDLE) ? (!req || (POST && bus.wr_en && !bus.rd_en)) : (state_q == DONE);
    assign bus.sram_addr   = SRAM_AW'(half_addr(addr_q, BASE_ADDR, hi));
    assign bus.sram_dq_oe  = wr_q & busy;
    assign bus.sram_dq_out = bus.sram_dq_oe ? (hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'd0;
    // Strobe released on the last cycle of each half for data hold.
    assign bus.sram_we_n   = !(bus.sram_dq_oe && !tc);
endmodule
